// File: rtl/mlite_dout_drain.sv
// Captures mlite_cpu output words into a small FIFO and drains them as bytes,
// high byte first, over a valid/ready handshake; reports occupancy and overflow.
module mlite_dout_drain #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              cap_en,
    input  logic [15:0]       din,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [15:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, ovf_q;

    state_t            state_q;
    logic [7:0]        hold_lo_q;
    logic [7:0]        byte_q;
    logic              valid_q;

    logic              push, pop;
    logic [15:0]       head;

    // Push is gated by the registered full flag only, so a same-cycle pop never
    // makes room for a capture that arrives while full.
    assign push = cap_en && !full_q;
    assign pop  = !empty_q && ((state_q == S_IDLE) || ((state_q == S_LO) && byte_ready));
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
            if (cap_en && full_q) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset_in) mem_q[wr_ptr_q] <= din;
    end

    // The high byte goes straight into the output register on a pop, so only
    // the low byte needs to be held for the second beat.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        hold_lo_q <= head[7:0];
                        byte_q    <= head[15:8];
                        valid_q   <= 1'b1;
                        state_q   <= S_HI;
                    end
                end
                S_HI: begin
                    if (byte_ready) begin
                        byte_q  <= hold_lo_q;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (byte_ready) begin
                        if (pop) begin
                            hold_lo_q <= head[7:0];
                            byte_q    <= head[15:8];
                            state_q   <= S_HI;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = ovf_q;

endmodule
